// File: rtl/oled_iic_pkg.sv
// oled_iic_pkg: shared state type and frame constants for the OLED IIC writer
package oled_iic_pkg;
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam int FRAME_TICKS = 116;
  localparam int BYTES_PER_FRAME = 3;
endpackage

// File: rtl/oled_iic_tick_gen.sv
// oled_iic_tick_gen: quarter-bit tick divider, held at zero while disabled
module oled_iic_tick_gen #(
  parameter int DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(DIV - 1);
  always_ff @(posedge sys_clk)
    cnt <= (sys_rst || !en || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/oled_iic_writer.sv
// oled_iic_writer: single-master IIC writer sending 3-byte frames to an OLED
module oled_iic_writer
  import oled_iic_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int IIC_FREQ = 400_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        write_req,
  input  logic [23:0] write_data,
  output logic        write_done,
  output logic        ack_err,
  output logic        busy,
  output logic        iic_scl,
  inout  wire         iic_sda
);
  localparam int DIV = CLK_FREQ / (4 * IIC_FREQ);
  if (DIV < 2) begin : g_div_chk
    $error("oled_iic_writer: CLK_FREQ/(4*IIC_FREQ) must be at least 2");
  end
  state_t      state;
  logic [1:0]  q;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;
  logic        nack;
  logic        sda_low;
  logic        tick;
  logic        last_ack;
  oled_iic_tick_gen #(.DIV(DIV)) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (state != IDLE && state != DONE),
    .tick    (tick)
  );
  assign iic_sda  = sda_low ? 1'b0 : 1'bz;
  assign last_ack = nack || byte_cnt == 2'(BYTES_PER_FRAME - 1);
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state      <= IDLE;
      q          <= Q0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      nack       <= 1'b0;
      iic_scl    <= 1'b1;
      sda_low    <= 1'b0;
      write_done <= 1'b0;
      ack_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (tick) q <= q + 2'd1;
      case (state)
        IDLE: if (write_req) begin
          shreg    <= write_data;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          nack     <= 1'b0;
          busy     <= 1'b1;
          state    <= START;
        end
        START: if (tick) case (q)
          Q0: sda_low <= 1'b1;
          Q2: iic_scl <= 1'b0;
          Q3: begin
            state   <= BIT;
            sda_low <= ~shreg[23];
          end
          default: ;
        endcase
        BIT: if (tick) case (q)
          Q0: iic_scl <= 1'b1;
          Q2: iic_scl <= 1'b0;
          Q3: begin
            shreg   <= {shreg[22:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            state   <= (bit_cnt == 3'd7) ? ACK : BIT;
            sda_low <= (bit_cnt == 3'd7) ? 1'b0 : ~shreg[22];
          end
          default: ;
        endcase
        ACK: if (tick) case (q)
          Q0: iic_scl <= 1'b1;
          Q2: begin
            iic_scl <= 1'b0;
            nack    <= nack | iic_sda;
          end
          Q3: begin
            byte_cnt <= last_ack ? byte_cnt : byte_cnt + 2'd1;
            state    <= last_ack ? STOP : BIT;
            sda_low  <= last_ack ? 1'b1 : ~shreg[23];
          end
          default: ;
        endcase
        STOP: if (tick) case (q)
          Q0: iic_scl <= 1'b1;
          Q1: sda_low <= 1'b0;
          Q3: begin
            state      <= DONE;
            write_done <= 1'b1;
            ack_err    <= nack;
          end
          default: ;
        endcase
        default: begin
          state      <= IDLE;
          write_done <= 1'b0;
          ack_err    <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_oled_iic_writer.sv
// tb_oled_iic_writer: random frames against a bus-level slave/decoder model
module tb_oled_iic_writer;
  localparam int CLK_FREQ = 1_600_000;
  localparam int IIC_FREQ = 100_000;
  localparam int DIV = CLK_FREQ / (4 * IIC_FREQ);
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        write_req = 1'b0;
  logic [23:0] write_data = '0;
  logic        write_done, ack_err, busy, iic_scl;
  wire         iic_sda;
  logic        slave_low = 1'b0;
  int          n_cmp = 0, n_err = 0, cyc = 0, nack_byte = -1;
  int          done_cnt = 0, done_cyc = 0, busy_cyc = 0, starts = 0, stops = 0;
  logic        done_err = 1'b0;
  logic [7:0]  cur[$];
  logic [7:0]  got[$];
  pullup (iic_sda);
  assign iic_sda = slave_low ? 1'b0 : 1'bz;
  oled_iic_writer #(.CLK_FREQ(CLK_FREQ), .IIC_FREQ(IIC_FREQ)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .write_req  (write_req),
    .write_data (write_data),
    .write_done (write_done),
    .ack_err    (ack_err),
    .busy       (busy),
    .iic_scl    (iic_scl),
    .iic_sda    (iic_sda)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  logic p_scl = 1'b1, p_sda = 1'b1, p_busy = 1'b0, p_done = 1'b0, p_rst = 1'b1;
  logic per_bad = 1'b1, skip;
  int   per = 0, rises = 0;
  logic [7:0] sh = '0;
  always @(negedge sys_clk) begin
    skip = sys_rst | p_rst;
    if (sys_rst) begin
      slave_low = 1'b0;
      rises = 0;
    end
    if (iic_sda !== p_sda) begin
      if (p_scl && iic_scl) begin
        per_bad = 1'b1;
        if (!skip && !iic_sda) begin
          starts++;
          rises = 0;
          cur.delete();
        end else if (!skip) begin
          stops++;
          got = cur;
        end
      end else if (!skip) check("sda_edge_needs_scl_low", {p_scl, iic_scl}, 0);
    end
    if (iic_scl !== p_scl) begin
      if (!skip && !per_bad) begin
        if (iic_scl) check("scl_low_len", per, 2 * DIV);
        else check("scl_high_len", per, 2 * DIV);
      end
      per = 1;
      per_bad = skip;
      if (iic_scl) begin
        if (rises % 9 == 8 && slave_low) check("ack_bit_low", iic_sda, 0);
        if (rises % 9 < 8) sh = {sh[6:0], iic_sda};
        rises++;
        if (rises % 9 == 8) cur.push_back(sh);
      end else if (rises % 9 == 8) slave_low = (rises / 9 != nack_byte);
      else if (rises % 9 == 0) slave_low = 1'b0;
    end else begin
      per++;
      if (skip) per_bad = 1'b1;
    end
    if (write_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = ack_err;
      check("busy_at_done", busy, 1);
    end
    if (p_done) check("busy_after_done", busy, 0);
    if (ack_err && !write_done) check("ack_err_only_with_done", ack_err, 0);
    if (busy && !p_busy) busy_cyc = cyc;
    p_scl  = iic_scl;
    p_sda  = iic_sda;
    p_busy = busy;
    p_done = write_done;
    p_rst  = sys_rst;
  end
  task automatic wait_done(input int target, input int budget);
    for (int k = 0; k < budget && done_cnt < target; k++) begin
      @(negedge sys_clk);
      #1;
    end
    check("done_seen", done_cnt, target);
  endtask
  task automatic check_frame(input logic [23:0] data, input int nb, input int t, input int s0, input int p0);
    int nbytes, ticks;
    nbytes = (nb < 0) ? 3 : nb + 1;
    ticks  = 4 + 36 * nbytes + 4;
    check("done_cycle", done_cyc - t, 1 + ticks * DIV);
    check("busy_rise", busy_cyc - t, 1);
    check("ack_err", done_err, int'(nb >= 0));
    check("starts", starts - s0, 1);
    check("stops", stops - p0, 1);
    check("nbytes", got.size(), nbytes);
    for (int i = 0; i < nbytes && i < got.size(); i++) check("byte", got[i], data[23 - 8 * i -: 8]);
  endtask
  task automatic run_frame(input logic [23:0] data, input int nb);
    int t, d0, s0, p0, nbytes;
    nbytes = (nb < 0) ? 3 : nb + 1;
    @(posedge sys_clk);
    #1;
    nack_byte = nb;
    write_data = data;
    write_req = 1'b1;
    t = cyc;
    d0 = done_cnt;
    s0 = starts;
    p0 = stops;
    @(posedge sys_clk);
    #1;
    write_req = 1'($urandom);
    write_data = 24'($urandom);
    wait_done(d0 + 1, (8 + 36 * nbytes) * DIV + 20);
    write_req = 1'b0;
    check_frame(data, nb, t, s0, p0);
  endtask
  initial begin
    int t, d0, s0, p0, r;
    repeat (4) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    check("rst_scl", iic_scl, 1);
    check("rst_sda", iic_sda, 1);
    check("rst_busy", busy, 0);
    check("rst_done", write_done, 0);
    check("rst_ack_err", ack_err, 0);
    run_frame(24'h7800AE, -1);
    run_frame(24'h7800AE, 0);
    @(posedge sys_clk);
    #1;
    nack_byte = -1;
    write_data = 24'h7800B0;
    write_req = 1'b1;
    t = cyc;
    d0 = done_cnt;
    s0 = starts;
    p0 = stops;
    wait_done(d0 + 1, 116 * DIV + 20);
    check_frame(24'h7800B0, -1, t, s0, p0);
    @(posedge sys_clk);
    #1;
    check("b2b_idle_busy", busy, 0);
    write_data = 24'h780000;
    t = cyc;
    s0 = starts;
    p0 = stops;
    wait_done(d0 + 2, 116 * DIV + 20);
    write_req = 1'b0;
    check_frame(24'h780000, -1, t, s0, p0);
    @(posedge sys_clk);
    #1;
    nack_byte = -1;
    write_data = 24'($urandom);
    write_req = 1'b1;
    d0 = done_cnt;
    @(posedge sys_clk);
    #1 write_req = 1'b0;
    repeat ((4 + 36 + 10) * DIV) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("abort_scl", iic_scl, 1);
    check("abort_sda", iic_sda, 1);
    check("abort_busy", busy, 0);
    write_req = 1'b1;
    @(posedge sys_clk);
    #1;
    check("rst_beats_req_busy", busy, 0);
    sys_rst = 1'b0;
    write_req = 1'b0;
    repeat (200) @(posedge sys_clk);
    #1 check("abort_no_done", done_cnt, d0);
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 4);
      run_frame(24'($urandom), (r > 2) ? -1 : r);
    end
    run_frame(24'h7800AF, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end
endmodule

// File: doc/oled_iic_writer.md
OLED_IIC_WRITER -- requirements
Module: oled_iic_writer

Interface
REQ-001 CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
REQ-002 IIC_FREQ, 400_000, SCL frequency in Hz; DIV = CLK_FREQ/(4*IIC_FREQ), integer division, DIV>=2 required (elaboration error otherwise).
REQ-003 sys_clk  input  1  single clock; all logic rising-edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 write_req  input  1  level request; a 3-byte frame is pending.
REQ-006 write_data  input  24  {slave addr, control byte, payload}, [23:16] sent first.
REQ-007 write_done  output  1  one-cycle pulse: frame finished, STOP issued.
REQ-008 ack_err  output  1  valid only with write_done; 1 = a NACK was received in this frame.
REQ-009 busy  output  1  high from frame acceptance until write_done inclusive.
REQ-010 iic_scl  output  1  SCL, push-pull (single master).
REQ-011 iic_sda  inout  1  SDA, open-drain: drives 0 or Z, never 1.

Function
REQ-012 Quarter tick: divider counts 0..DIV-1 while not IDLE and fires a tick when count==DIV-1; divider held at 0 in IDLE.
REQ-013 States: IDLE, START, BIT, ACK, STOP, DONE; each bus phase (START, each BIT, each ACK, STOP) lasts exactly 4 ticks, quarters q0..q3.
REQ-014 IDLE: write_req=1 latches write_data into shift register and enters START next cycle (acceptance cycle T); busy=1 from T+1.
REQ-015 START: q0 SCL=1 SDA=Z; q1,q2 SCL=1 SDA=0; q3 SCL=0 SDA=0; then BIT.
REQ-016 BIT: SDA set to current MSB at q0 with SCL=0; SCL=1 in q1,q2; SCL=0 in q3; shift left at end of q3; after 8 bits go to ACK.
REQ-017 ACK: SDA released all 4 quarters; SCL as in BIT; SDA sampled at last cycle of q2; 1 = NACK.
REQ-018 After ACK: ACK on byte 0/1 -> BIT of next byte; ACK on byte 2 or any NACK -> STOP (remaining bytes skipped).
REQ-019 STOP: q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2,q3 SCL=1 SDA=Z; then DONE.
REQ-020 DONE: lasts one cycle; write_done=1, ack_err=NACK flag, busy=1; next cycle IDLE.
REQ-021 Full ACKed frame: 116 ticks; write_done asserted in cycle T+1+116*DIV.
REQ-022 write_req sampled only in IDLE; changes to write_req/write_data while busy are ignored.
REQ-023 Back-to-back: write_req high in the IDLE cycle following DONE starts the next frame; upstream's data update on write_done is therefore captured (minimum one idle cycle between frames).
REQ-024 Byte counter 0..2 and bit counter 0..7 wrap to 0 on frame acceptance.
REQ-025 Outside IDLE/DONE, SCL=0 at every SDA transition except START q1 and STOP q2.

Reset
REQ-026 sys_rst=1 forces IDLE, divider=0, counters=0, NACK flag=0; outputs: iic_scl=1, iic_sda=Z, write_done=0, ack_err=0, busy=0.
REQ-027 Reset mid-frame aborts immediately: bus released next cycle, no STOP generated, no write_done pulse.
REQ-028 Reset dominates write_req in the same cycle.

Structure
REQ-029 Package oled_iic_pkg holds: state enumeration, quarter-index constants, FRAME_TICKS=116, BYTES_PER_FRAME=3.
REQ-030 One sub-module oled_iic_tick_gen (DIV-parameterised divider with enable, tick output); FSM, shifter and counters in oled_iic_writer.

Verification
REQ-031 CLK_FREQ=1_600_000, IIC_FREQ=100_000 (DIV=4), slave model ACKs all, write_data=24'h7800AE -> bytes 78,00,AE on bus MSB-first, write_done at T+465, ack_err=0.
REQ-032 Same setup, slave NACKs byte 0 -> STOP after first ACK slot, write_done at T+1+44*4=T+177, ack_err=1, bytes 1-2 absent.
REQ-033 write_req held high with model updating write_data on write_done (78/00/B0 then 78/00/00) -> two frames, one IDLE cycle between, second frame carries second word.
REQ-034 sys_rst pulsed during byte 1 -> iic_scl=1, iic_sda=Z, busy=0 next cycle, no write_done; later request completes normally.
REQ-035 Protocol checker over all runs: SDA never driven 1, SDA changes only with SCL=0 except START/STOP, SCL high/low each exactly 2*DIV cycles per bit.
